// File: rtl/sumador_serial_4bit.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flip-flop, LSB first,
// with a start/busy/done handshake and registered S/Cout/ovf.
module sumador_serial_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             sb;
  logic             c_next;
  logic             last;

  always_comb begin
    sb     = a_sh[0] ^ b_sh[0] ^ c;
    c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            c     <= Cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          c    <= c_next;
          s_sh <= {sb, s_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          // c still holds the carry into the MSB while the final bit is summed
          if (last) begin
            S     <= {sb, s_sh[WIDTH-1:1]};
            Cout  <= c_next;
            ovf   <= c ^ c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial_4bit.sv
// Self-checking bench: a cycle-count/arithmetic model predicts busy/done/S/Cout/ovf,
// one compare process checks every cycle, literal pins anchor selected results.
module tb_sumador_serial_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // Literal expectations handed from the stimulus to the compare process.
  logic         pin_en = 1'b0;
  logic         pin_full = 1'b1;
  logic [W-1:0] pin_s = '0;
  logic         pin_c = 1'b0;
  logic         pin_o = 1'b0;

  always #5 clk = ~clk;

  sumador_serial_4bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .S    (S),
    .Cout (Cout),
    .ovf  (ovf)
  );

  // Reference: count edges since acceptance, compute the result arithmetically.
  int           k = -1;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic [W-1:0] exp_s = '0;
  logic         exp_c = 1'b0;
  logic         exp_o = 1'b0;
  int           pend_sum;
  logic         pend_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = -1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_s = '0;
      exp_c = 1'b0;
      exp_o = 1'b0;
    end else if (k < 0) begin
      if (start === 1'b1) begin
        int sa, sbv, ssum;
        k = 0;
        exp_busy = 1'b1;
        pend_sum = int'(A) + int'(B) + int'(Cin);
        sa   = (int'(A) >= (1 << (W - 1))) ? int'(A) - (1 << W) : int'(A);
        sbv  = (int'(B) >= (1 << (W - 1))) ? int'(B) - (1 << W) : int'(B);
        ssum = sa + sbv + int'(Cin);
        pend_o = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
      end
    end else begin
      k = k + 1;
      if (k == W) begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_s = W'(pend_sum % (1 << W));
        exp_c = (pend_sum >= (1 << W));
        exp_o = pend_o;
      end else if (k == W + 1) begin
        exp_done = 1'b0;
        k = -1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("S", 32'(S), 32'(exp_s));
    chk("Cout", 32'(Cout), 32'(exp_c));
    chk("ovf", 32'(ovf), 32'(exp_o));
    chk("busy_and_done", 32'(busy & done), 32'd0);
    if (done === 1'b1 && pin_en) begin
      chk("pin_S", 32'(S), 32'(pin_s));
      chk("pin_model_S", 32'(exp_s), 32'(pin_s));
      if (pin_full) begin
        chk("pin_Cout", 32'(Cout), 32'(pin_c));
        chk("pin_ovf", 32'(ovf), 32'(pin_o));
        chk("pin_model_Cout", 32'(exp_c), 32'(pin_c));
        chk("pin_model_ovf", 32'(exp_o), 32'(pin_o));
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    $display("FAIL done_timeout: done not seen within 40 cycles at %0t", $time);
    $fatal(1, "done timeout");
  endtask

  task automatic set_pin(input logic [W-1:0] s, input logic c, input logic o, input logic full);
    pin_s = s;
    pin_c = c;
    pin_o = o;
    pin_full = full;
    pin_en = 1'b1;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                    input logic noisy);
    @(negedge clk);
    A = a;
    B = b;
    Cin = cin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (noisy) begin
      for (int i = 0; i < 40; i++) begin
        A = W'($urandom);
        B = W'($urandom);
        Cin = 1'($urandom);
        start = 1'($urandom);
        @(negedge clk);
        if (done === 1'b1) break;
      end
      if (done !== 1'b1) begin
        $display("FAIL done_timeout: noisy op got no done at %0t", $time);
        $fatal(1, "done timeout");
      end
    end else begin
      wait_done();
    end
    #1 pin_en = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic op with signed overflow
    set_pin(4'd8, 1'b0, 1'b1, 1'b1);
    op(4'd3, 4'd5, 1'b0, 1'b0);

    set_pin(4'd15, 1'b1, 1'b0, 1'b1);
    op(4'd15, 4'd15, 1'b1, 1'b0);
    set_pin(4'd8, 1'b0, 1'b1, 1'b1);
    op(4'd7, 4'd1, 1'b0, 1'b0);
    set_pin(4'd0, 1'b1, 1'b1, 1'b1);
    op(4'd8, 4'd8, 1'b0, 1'b0);

    // Second start during RUN is ignored
    set_pin(4'd6, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    A = 4'd2; B = 4'd4; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd9; B = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    #1 pin_en = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of RUN aborts
    @(negedge clk);
    A = 4'd10; B = 4'd5; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    set_pin(4'd2, 1'b0, 1'b0, 1'b1);
    op(4'd1, 4'd1, 1'b0, 1'b0);

    // start held high: one result every W+2 cycles
    set_pin(4'd13, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    A = 4'd4; B = 4'd9; Cin = 1'b0; start = 1'b1;
    repeat (18) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1 pin_en = 1'b0;

    // Exhaustive sweep; subtractor cross-check (A-B)+B == A
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          op(W'(a), W'(b), 1'(ci), 1'b0);
        end
        set_pin(W'(a), 1'b0, 1'b0, 1'b0);
        op(W'(a - b), W'(b), 1'b0, 1'b0);
      end
    end

    // Random operands with input noise during RUN
    for (int n = 0; n < 150; n++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
